// File: rtl/tlb_csr_controller.sv
// rtl/tlb_csr_controller.sv - TLB maintenance CSR owner and MMU request sequencer
module tlb_csr_controller #(
  parameter int TLB_n     = 3,
  parameter int TLB_PALEN = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic [4:0]  req_subtype,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_rj,
  input  logic [31:0] req_rk,
  output logic        req_ready,
  output logic        req_done,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [13:0] csr_raddr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        excp_tlbr,
  input  logic [31:0] excp_badv,
  output logic [3:0]  mmu_type,
  output logic [4:0]  mmu_subtype,
  output logic [15:0] mmu_excp_arg,
  output logic [31:0] mmu_rj,
  output logic [31:0] mmu_rk,
  output logic [31:0] mmu_TLBIDX,
  output logic [31:0] mmu_TLBEHI,
  output logic [31:0] mmu_TLBELO0,
  output logic [31:0] mmu_TLBELO1,
  output logic [9:0]  mmu_ASID,
  input  logic [31:0] mmu_rd_TLBIDX,
  input  logic [31:0] mmu_rd_TLBEHI,
  input  logic [31:0] mmu_rd_TLBELO0,
  input  logic [31:0] mmu_rd_TLBELO1,
  input  logic [9:0]  mmu_rd_ASID
);

  localparam logic [4:0]  SUB_SRCH = 5'd1;
  localparam logic [4:0]  SUB_RD   = 5'd2;
  localparam logic [4:0]  SUB_FILL = 5'd4;
  localparam logic [3:0]  TLB_TYPE = 4'd11;

  localparam logic [13:0] A_TLBIDX  = 14'h10;
  localparam logic [13:0] A_TLBEHI  = 14'h11;
  localparam logic [13:0] A_TLBELO0 = 14'h12;
  localparam logic [13:0] A_TLBELO1 = 14'h13;
  localparam logic [13:0] A_ASID    = 14'h18;

  // Bits that software and the MMU may set; everything else reads as zero.
  localparam logic [31:0] IDX_MASK = 32'hBF00_0000 | ((32'd1 << TLB_n) - 32'd1);
  localparam logic [31:0] EHI_MASK = 32'hFFFF_E000;
  localparam logic [31:0] ELO_MASK = (((32'd1 << (TLB_PALEN - 4)) - 32'd1) & 32'hFFFF_FF00)
                                     | 32'h0000_007F;
  localparam logic [TLB_n-1:0] FILL_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        sub_q, op_q;
  logic [31:0]       rj_q, rk_q;
  logic [TLB_n-1:0]  fill_ptr_q;
  logic [31:0]       tlbidx_q, tlbehi_q, tlbelo0_q, tlbelo1_q;
  logic [9:0]        asid_q;

  logic accept, capt_srch, capt_rd, issue_fill;

  assign accept     = (state_q == S_IDLE) && req_valid;
  assign capt_srch  = (state_q == S_CAPT) && (sub_q == SUB_SRCH);
  assign capt_rd    = (state_q == S_CAPT) && (sub_q == SUB_RD);
  assign issue_fill = (state_q == S_ISSUE) && (sub_q == SUB_FILL);

  // State register; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake/MMU command outputs.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    req_done    = 1'b0;
    mmu_type    = 4'd0;
    mmu_subtype = 5'd0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mmu_type    = TLB_TYPE;
        mmu_subtype = sub_q;
        state_d     = ((sub_q == SUB_SRCH) || (sub_q == SUB_RD)) ? S_CAPT : S_DONE;
      end
      S_CAPT:  state_d = S_DONE;
      S_DONE: begin
        req_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, held for the whole operation so the MMU sees stable operands.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sub_q <= '0;
      op_q  <= '0;
      rj_q  <= '0;
      rk_q  <= '0;
    end else if (accept) begin
      sub_q <= req_subtype;
      op_q  <= req_op;
      rj_q  <= req_rj;
      rk_q  <= req_rk;
    end
  end

  // Round-robin fill slot, advanced once per FILL as it leaves ISSUE.
  always_ff @(posedge clk) begin
    if (!rstn)           fill_ptr_q <= '0;
    else if (issue_fill) fill_ptr_q <= fill_ptr_q + FILL_ONE;
  end

  // CSR updates: MMU capture beats refill exception beats software write, per register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tlbidx_q  <= '0;
      tlbehi_q  <= '0;
      tlbelo0_q <= '0;
      tlbelo1_q <= '0;
      asid_q    <= '0;
    end else begin
      if (capt_srch || capt_rd)
        tlbidx_q <= mmu_rd_TLBIDX & IDX_MASK;
      else if (csr_we && (csr_waddr == A_TLBIDX))
        tlbidx_q <= csr_wdata & IDX_MASK;

      if (capt_rd)
        tlbehi_q <= mmu_rd_TLBEHI & EHI_MASK;
      else if (excp_tlbr)
        tlbehi_q <= excp_badv & EHI_MASK;
      else if (csr_we && (csr_waddr == A_TLBEHI))
        tlbehi_q <= csr_wdata & EHI_MASK;

      if (capt_rd)
        tlbelo0_q <= mmu_rd_TLBELO0 & ELO_MASK;
      else if (csr_we && (csr_waddr == A_TLBELO0))
        tlbelo0_q <= csr_wdata & ELO_MASK;

      if (capt_rd)
        tlbelo1_q <= mmu_rd_TLBELO1 & ELO_MASK;
      else if (csr_we && (csr_waddr == A_TLBELO1))
        tlbelo1_q <= csr_wdata & ELO_MASK;

      if (capt_rd)
        asid_q <= mmu_rd_ASID;
      else if (csr_we && (csr_waddr == A_ASID))
        asid_q <= csr_wdata[9:0];
    end
  end

  // Combinational CSR read port; unmapped addresses return zero.
  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      A_TLBIDX:  csr_rdata = tlbidx_q;
      A_TLBEHI:  csr_rdata = tlbehi_q;
      A_TLBELO0: csr_rdata = tlbelo0_q;
      A_TLBELO1: csr_rdata = tlbelo1_q;
      A_ASID:    csr_rdata = {22'd0, asid_q};
      default:   csr_rdata = 32'd0;
    endcase
  end

  // FILL targets the rotating slot instead of the software index, only while issuing.
  always_comb begin
    mmu_TLBIDX = tlbidx_q;
    if (issue_fill) mmu_TLBIDX[TLB_n-1:0] = fill_ptr_q;
  end

  assign mmu_excp_arg = {11'd0, op_q};
  assign mmu_rj       = rj_q;
  assign mmu_rk       = rk_q;
  assign mmu_TLBEHI   = tlbehi_q;
  assign mmu_TLBELO0  = tlbelo0_q;
  assign mmu_TLBELO1  = tlbelo1_q;
  assign mmu_ASID     = asid_q;

endmodule

// File: tb/tb_tlb_csr_controller.sv
// tb/tb_tlb_csr_controller.sv - self-checking bench for tlb_csr_controller
module tb_tlb_csr_controller;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic [4:0]  req_subtype, req_op;
  logic [31:0] req_rj, req_rk;
  logic        req_ready, req_done;
  logic        csr_we;
  logic [13:0] csr_waddr, csr_raddr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        excp_tlbr;
  logic [31:0] excp_badv;
  logic [3:0]  mmu_type;
  logic [4:0]  mmu_subtype;
  logic [15:0] mmu_excp_arg;
  logic [31:0] mmu_rj, mmu_rk;
  logic [31:0] mmu_TLBIDX, mmu_TLBEHI, mmu_TLBELO0, mmu_TLBELO1;
  logic [9:0]  mmu_ASID;
  logic [31:0] mmu_rd_TLBIDX, mmu_rd_TLBEHI, mmu_rd_TLBELO0, mmu_rd_TLBELO1;
  logic [9:0]  mmu_rd_ASID;

  always #5 clk = ~clk;

  tlb_csr_controller #(.TLB_n(3), .TLB_PALEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_subtype(req_subtype), .req_op(req_op),
    .req_rj(req_rj), .req_rk(req_rk), .req_ready(req_ready), .req_done(req_done),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_raddr(csr_raddr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .excp_tlbr(excp_tlbr), .excp_badv(excp_badv),
    .mmu_type(mmu_type), .mmu_subtype(mmu_subtype), .mmu_excp_arg(mmu_excp_arg),
    .mmu_rj(mmu_rj), .mmu_rk(mmu_rk),
    .mmu_TLBIDX(mmu_TLBIDX), .mmu_TLBEHI(mmu_TLBEHI),
    .mmu_TLBELO0(mmu_TLBELO0), .mmu_TLBELO1(mmu_TLBELO1), .mmu_ASID(mmu_ASID),
    .mmu_rd_TLBIDX(mmu_rd_TLBIDX), .mmu_rd_TLBEHI(mmu_rd_TLBEHI),
    .mmu_rd_TLBELO0(mmu_rd_TLBELO0), .mmu_rd_TLBELO1(mmu_rd_TLBELO1),
    .mmu_rd_ASID(mmu_rd_ASID)
  );

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  // Reference model: CSR contents indexed TLBIDX, TLBEHI, TLBELO0, TLBELO1, ASID,
  // plus the number of cycles elapsed since the current request was accepted.
  logic [31:0] m_csr [5];
  int          m_k;
  logic [4:0]  m_sub, m_op;
  logic [31:0] m_rj, m_rk;
  int          m_fill;

  function automatic int csr_idx(input logic [13:0] a);
    case (a)
      14'h10:  return 0;
      14'h11:  return 1;
      14'h12:  return 2;
      14'h13:  return 3;
      14'h18:  return 4;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] wmask(input int i);
    case (i)
      0:       return 32'hBF00_0007;
      1:       return 32'hFFFF_E000;
      2, 3:    return 32'h0FFF_FF7F;
      default: return 32'h0000_03FF;
    endcase
  endfunction

  function automatic int latency(input logic [4:0] s);
    return (s == 5'd1 || s == 5'd2) ? 3 : 2;
  endfunction

  task automatic model_edge();
    logic [31:0] n [5];
    int wi;
    if (!rstn) begin
      for (int i = 0; i < 5; i++) m_csr[i] = 32'd0;
      m_k = 0; m_sub = '0; m_op = '0; m_rj = '0; m_rk = '0; m_fill = 0;
      return;
    end
    for (int i = 0; i < 5; i++) n[i] = m_csr[i];
    wi = csr_idx(csr_waddr);
    if (csr_we && wi >= 0) n[wi] = csr_wdata & wmask(wi);
    if (excp_tlbr) n[1] = excp_badv & wmask(1);
    if (m_k == 2 && m_sub == 5'd1) n[0] = mmu_rd_TLBIDX & wmask(0);
    if (m_k == 2 && m_sub == 5'd2) begin
      n[0] = mmu_rd_TLBIDX & wmask(0);
      n[1] = mmu_rd_TLBEHI & wmask(1);
      n[2] = mmu_rd_TLBELO0 & wmask(2);
      n[3] = mmu_rd_TLBELO1 & wmask(3);
      n[4] = {22'd0, mmu_rd_ASID};
    end
    for (int i = 0; i < 5; i++) m_csr[i] = n[i];
    if (m_k == 0) begin
      if (req_valid) begin
        m_k = 1; m_sub = req_subtype; m_op = req_op; m_rj = req_rj; m_rk = req_rk;
      end
    end else begin
      if (m_k == 1 && m_sub == 5'd4) m_fill = (m_fill + 1) % 8;
      if (m_k == latency(m_sub)) m_k = 0;
      else                       m_k = m_k + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic read_chk(input string name, input logic [13:0] a, input logic [31:0] exp);
    csr_raddr = a;
    @(negedge clk);
    chk(name, csr_rdata, exp);
    tick();
  endtask

  task automatic quiet_inputs();
    req_valid = 1'b0; csr_we = 1'b0; excp_tlbr = 1'b0;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      int ci;
      logic [31:0] eidx;
      ci = csr_idx(csr_raddr);
      eidx = m_csr[0];
      if (m_k == 1 && m_sub == 5'd4) eidx[2:0] = 3'(m_fill);
      chk("req_ready", 32'(req_ready), 32'(m_k == 0));
      chk("req_done", 32'(req_done), 32'(m_k != 0 && m_k == latency(m_sub)));
      chk("mmu_type", 32'(mmu_type), (m_k == 1) ? 32'd11 : 32'd0);
      chk("mmu_subtype", 32'(mmu_subtype), (m_k == 1) ? 32'(m_sub) : 32'd0);
      chk("mmu_excp_arg", 32'(mmu_excp_arg), 32'(m_op));
      chk("mmu_rj", mmu_rj, m_rj);
      chk("mmu_rk", mmu_rk, m_rk);
      chk("mmu_TLBIDX", mmu_TLBIDX, eidx);
      chk("mmu_TLBEHI", mmu_TLBEHI, m_csr[1]);
      chk("mmu_TLBELO0", mmu_TLBELO0, m_csr[2]);
      chk("mmu_TLBELO1", mmu_TLBELO1, m_csr[3]);
      chk("mmu_ASID", 32'(mmu_ASID), m_csr[4]);
      chk("csr_rdata", csr_rdata, (ci < 0) ? 32'd0 : m_csr[ci]);
    end
  end

  logic [13:0] addr_tab [6] = '{14'h10, 14'h11, 14'h12, 14'h13, 14'h18, 14'h14};

  initial begin
    rstn = 1'b0; quiet_inputs();
    req_subtype = '0; req_op = '0; req_rj = '0; req_rk = '0;
    csr_waddr = '0; csr_raddr = 14'h10; csr_wdata = '0; excp_badv = '0;
    mmu_rd_TLBIDX = '0; mmu_rd_TLBEHI = '0; mmu_rd_TLBELO0 = '0;
    mmu_rd_TLBELO1 = '0; mmu_rd_ASID = '0;
    for (int i = 0; i < 5; i++) m_csr[i] = 32'hDEAD_BEEF;
    m_k = 0; m_fill = 0;

    // Reset
    tick(); tick();
    mon_en = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_type", 32'(mmu_type), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) read_chk("rst_rdata", addr_tab[i], 32'd0);

    // Writable-bit masks
    csr_we = 1'b1; csr_waddr = 14'h10; csr_wdata = 32'hFFFF_FFFF;
    tick(); csr_we = 1'b0;
    read_chk("mask_tlbidx", 14'h10, 32'hBF00_0007);
    csr_we = 1'b1; csr_waddr = 14'h11; csr_wdata = 32'hFFFF_FFFF;
    tick(); csr_we = 1'b0;
    read_chk("mask_tlbehi", 14'h11, 32'hFFFF_E000);

    // TLBSRCH with a known MMU result
    mmu_rd_TLBIDX = 32'h0C00_0005;
    req_valid = 1'b1; req_subtype = 5'd1;
    tick(); req_valid = 1'b0;
    @(negedge clk);
    chk("srch_type", 32'(mmu_type), 32'd11);
    chk("srch_sub", 32'(mmu_subtype), 32'd1);
    tick();
    @(negedge clk);
    chk("srch_type_off", 32'(mmu_type), 32'd0);
    chk("srch_nodone", 32'(req_done), 32'd0);
    tick();
    @(negedge clk);
    chk("srch_done", 32'(req_done), 32'd1);
    tick();
    read_chk("srch_idx", 14'h10, 32'h0C00_0005);

    // Nine back-to-back FILLs walk and wrap the fill pointer
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1; req_subtype = 5'd4;
      tick(); req_valid = 1'b0;
      @(negedge clk);
      chk("fill_ptr", 32'(mmu_TLBIDX[2:0]), 32'(i % 8));
      chk("fill_type", 32'(mmu_type), 32'd11);
      tick();
      @(negedge clk);
      chk("fill_done", 32'(req_done), 32'd1);
      tick();
    end
    read_chk("fill_idx_kept", 14'h10, 32'h0C00_0005);

    // Refill exception collides with a software TLBEHI write
    excp_tlbr = 1'b1; excp_badv = 32'h1234_5678;
    csr_we = 1'b1; csr_waddr = 14'h11; csr_wdata = 32'hFFFF_E000;
    tick(); quiet_inputs();
    read_chk("collide_ehi", 14'h11, 32'h1234_4000);

    // Reset during CAPT of a TLBRD
    mmu_rd_TLBIDX = 32'hFFFF_FFFF; mmu_rd_TLBEHI = 32'hFFFF_FFFF;
    mmu_rd_TLBELO0 = 32'hFFFF_FFFF; mmu_rd_TLBELO1 = 32'hFFFF_FFFF; mmu_rd_ASID = 10'h3FF;
    req_valid = 1'b1; req_subtype = 5'd2; req_rj = 32'hA5A5_0001;
    tick(); req_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_nodone", 32'(req_done), 32'd0);
    chk("rstmid_rj", mmu_rj, 32'd0);
    tick();
    @(negedge clk);
    chk("rstmid_nodone2", 32'(req_done), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) read_chk("rstmid_rdata", addr_tab[i], 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rstn        = ($urandom_range(0, 299) != 0);
      req_valid   = ($urandom_range(0, 2) != 0);
      req_subtype = 5'($urandom_range(0, 7));
      req_op      = 5'($urandom);
      req_rj      = $urandom;
      req_rk      = $urandom;
      csr_we      = ($urandom_range(0, 2) == 0);
      csr_waddr   = addr_tab[$urandom_range(0, 5)];
      csr_raddr   = addr_tab[$urandom_range(0, 5)];
      csr_wdata   = $urandom;
      excp_tlbr   = ($urandom_range(0, 7) == 0);
      excp_badv   = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        mmu_rd_TLBIDX = '0; mmu_rd_TLBEHI = '0; mmu_rd_TLBELO0 = '0;
        mmu_rd_TLBELO1 = '0; mmu_rd_ASID = '0;
      end else begin
        mmu_rd_TLBIDX = $urandom; mmu_rd_TLBEHI = $urandom; mmu_rd_TLBELO0 = $urandom;
        mmu_rd_TLBELO1 = $urandom; mmu_rd_ASID = 10'($urandom);
      end
      tick();
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
